fifo_byte_sequencer: RTL and testbench
======================================

// Module: fifo_byte_sequencer
// PURPOSE
//  Drains 32-bit words from the capture FIFO and sends each word as four bytes to the UART transmitter.
//  Uses a start/busy handshake on the UART side.
//  Sits between the sample FIFO read port and the UART TX.
//  Sequences the FIFO read, word latch, byte rotation and per-byte TX handshake.
//  A dump is either a fixed number of words or a drain of the FIFO until it is empty.
// PARAMETERS
//  WORD_W      32  FIFO word width; must be a multiple of 8
//  FIFO_RD_LAT 1   cycles from FifoReadEn high to FifoData valid (1 or 2)
//  CNT_W       16  width of WordCount / WordsSent
// PORTS
//  Clock      in   1       system clock, rising edge
//  Reset_n    in   1       asynchronous, active-low reset
//  Start      in   1       1-cycle pulse: begin a dump (ignored while Busy)
//  Abort      in   1       level: terminate the dump at once
//  WordCount  in   CNT_W   words to send; sampled on Start; 0 = drain until FifoEmpty
//  FifoData   in   WORD_W  FIFO read data
//  FifoEmpty  in   1       FIFO empty flag
//  FifoReadEn out  1       1-cycle FIFO pop strobe
//  TxBusy     in   1       UART busy; rises the cycle after TxStart, falls when the byte is done
//  TxStart    out  1       1-cycle pulse: send TxData
//  TxData     out  8       byte to send; held stable from TxStart until TxBusy falls
//  Busy       out  1       high from the cycle after Start until the cycle after Done/abort
//  Done       out  1       1-cycle pulse on normal completion
//  WordsSent  out  CNT_W   words fully sent in the current/last dump
// BEHAVIOUR
//  Reset (Reset_n low, async):
//   - state IDLE; all outputs 0; internal word register and byte index 0.
//  States:
//   - IDLE: on Start -> latch WordCount, clear WordsSent, go to CHK.
//   - CHK, FifoEmpty=1, count mode (WordCount!=0): stay in CHK (stall).
//   - CHK, FifoEmpty=1, drain mode: pulse Done, go to IDLE.
//   - CHK, FifoEmpty=0: assert FifoReadEn for exactly one cycle, go to RD.
//   - RD: wait FIFO_RD_LAT cycles, latch FifoData, byte index=0, go to TXWAIT.
//   - TXWAIT: when TxBusy=0 -> TxStart=1, TxData=byte[index], go to GUARD.
//   - GUARD: one cycle, not checking TxBusy (covers the 1-cycle UART rise latency), go to TXBUSY.
//   - TXBUSY: when TxBusy=0 -> byte done.
//     - If index<WORD_W/8-1: index+1, go to TXWAIT.
//     - Else: WordsSent+1 and go to NEXT.
//   - NEXT, count mode and WordsSent==WordCount: pulse Done, go to IDLE.
//   - NEXT, otherwise: go to CHK.
//  Byte order: MSB first, i.e. byte0=word[WORD_W-1:WORD_W-8].
//  Latency: Start at cycle 0 with FIFO non-empty and UART idle, FIFO_RD_LAT=1:
//   - FifoReadEn in cycle 2, first TxStart in cycle 4.
//  Counters:
//   - WordsSent saturates at all-ones.
//   - Drain mode never terminates on count.
//   - WordCount is not re-sampled mid-dump.
//  Boundary conditions:
//   - Start while Busy: ignored.
//   - Start and Abort in the same cycle: Abort wins, stay in IDLE.
//   - Abort in any state: go to IDLE next cycle.
//     - No Done; TxStart/FifoReadEn low from that cycle; WordsSent holds.
//     - An in-flight UART byte is left to finish.
//     - A popped but unsent word is discarded.
//   - FifoEmpty rising after a pop has no effect on the latched word.
//   - TxBusy never rising after TxStart: GUARD still exits, and TXBUSY sees TxBusy=0.
//     - The byte counts as sent; there is no deadlock.
//   - Reset mid-dump: immediate return to reset state; the FIFO word in flight is lost.
// TESTING
//  T1 WordCount=1, FIFO holds 0xA1B2C3D4, UART TxBusy lasts 10 cycles:
//     -> TxData A1,B2,C3,D4 in order, 4 TxStart pulses, Done once, WordsSent=1.
//  T2 WordCount=0, FIFO holds 3 words:
//     -> 12 bytes sent, exactly 3 FifoReadEn pulses, Done after the last byte, WordsSent=3.
//  T3 WordCount=2, FIFO holds 1 word, second word pushed 50 cycles later:
//     -> stall in CHK, no extra FifoReadEn, 8 bytes total, Done, WordsSent=2.
//  T4 Abort asserted during the 2nd byte of word 1:
//     -> IDLE next cycle, no Done, WordsSent=0, no further TxStart.
//     -> A new Start then completes normally.
//  T5 Start pulsed again while Busy, and Start+Abort in the same cycle:
//     -> no effect, and no dump begins, respectively.
//  T6 Reset_n pulsed low mid-TXBUSY, asynchronously to Clock:
//     -> all outputs 0 immediately, state IDLE.

Source files
------------

// File: rtl/fifo_byte_sequencer_if.sv
// Bundles the sequencer's control, FIFO read port and UART TX handshake.
// The slave modport is the sequencer; the master modport is its surroundings.
interface fifo_byte_sequencer_if #(
  parameter int WORD_W = 32,
  parameter int CNT_W  = 16
);
  logic              Start;
  logic              Abort;
  logic [CNT_W-1:0]  WordCount;
  logic [WORD_W-1:0] FifoData;
  logic              FifoEmpty;
  logic              FifoReadEn;
  logic              TxBusy;
  logic              TxStart;
  logic [7:0]        TxData;
  logic              Busy;
  logic              Done;
  logic [CNT_W-1:0]  WordsSent;

  modport slave (
    input  Start, Abort, WordCount, FifoData, FifoEmpty, TxBusy,
    output FifoReadEn, TxStart, TxData, Busy, Done, WordsSent
  );

  modport master (
    output Start, Abort, WordCount, FifoData, FifoEmpty, TxBusy,
    input  FifoReadEn, TxStart, TxData, Busy, Done, WordsSent
  );
endinterface

// File: rtl/fifo_byte_sequencer.sv
// Drains FIFO words and sends each as bytes, MSB first, over a start/busy UART handshake.
//
//  state    | meaning
//  ---------+-----------------------------------------------------------
//  S_IDLE   | waiting for Start
//  S_CHK    | decide: pop a word, stall on empty (count mode), or finish (drain mode)
//  S_RD     | pop strobe in first cycle, then wait for FIFO read latency and latch word
//  S_TXWAIT | wait for UART idle, then pulse TxStart
//  S_GUARD  | one cycle skipped while the UART raises TxBusy
//  S_TXBUSY | wait for the byte to finish; advance byte or word
//  S_NEXT   | word finished: check count-mode termination
module fifo_byte_sequencer #(
  parameter int WORD_W      = 32,
  parameter int FIFO_RD_LAT = 1,
  parameter int CNT_W       = 16
) (
  input  logic                  Clock,
  input  logic                  Reset_n,
  fifo_byte_sequencer_if.slave  bus
);
  localparam int NB    = WORD_W / 8;
  localparam int IDX_W = (NB > 1) ? $clog2(NB) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHK,
    S_RD,
    S_TXWAIT,
    S_GUARD,
    S_TXBUSY,
    S_NEXT
  } state_t;

  state_t              state_q, state_d;
  logic [WORD_W-1:0]   word_q, word_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [1:0]          rd_cnt_q, rd_cnt_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [CNT_W-1:0]    words_sent_q, words_sent_d;

  logic                fifo_rd_en;
  logic                tx_start;
  logic                done;
  logic [7:0]          tx_byte;

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q      <= S_IDLE;
      word_q       <= '0;
      idx_q        <= '0;
      rd_cnt_q     <= '0;
      count_q      <= '0;
      words_sent_q <= '0;
    end else begin
      state_q      <= state_d;
      word_q       <= word_d;
      idx_q        <= idx_d;
      rd_cnt_q     <= rd_cnt_d;
      count_q      <= count_d;
      words_sent_q <= words_sent_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    word_d       = word_q;
    idx_d        = idx_q;
    rd_cnt_d     = rd_cnt_q;
    count_d      = count_q;
    words_sent_d = words_sent_q;
    fifo_rd_en   = 1'b0;
    tx_start     = 1'b0;
    done         = 1'b0;

    // Abort overrides everything, including a same-cycle Start
    if (bus.Abort) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (bus.Start) begin
            count_d      = bus.WordCount;
            words_sent_d = '0;
            state_d      = S_CHK;
          end
        end
        S_CHK: begin
          if (!bus.FifoEmpty) begin
            rd_cnt_d = '0;
            state_d  = S_RD;
          end else if (count_q == '0) begin
            done    = 1'b1;
            state_d = S_IDLE;
          end
        end
        S_RD: begin
          fifo_rd_en = (rd_cnt_q == 2'd0);
          if (rd_cnt_q == 2'(FIFO_RD_LAT)) begin
            word_d  = bus.FifoData;
            idx_d   = '0;
            state_d = S_TXWAIT;
          end else begin
            rd_cnt_d = rd_cnt_q + 2'd1;
          end
        end
        S_TXWAIT: begin
          if (!bus.TxBusy) begin
            tx_start = 1'b1;
            state_d  = S_GUARD;
          end
        end
        S_GUARD: begin
          state_d = S_TXBUSY;
        end
        S_TXBUSY: begin
          if (!bus.TxBusy) begin
            if (idx_q != IDX_W'(NB - 1)) begin
              idx_d   = idx_q + 1'b1;
              state_d = S_TXWAIT;
            end else begin
              if (words_sent_q != '1) begin
                words_sent_d = words_sent_q + 1'b1;
              end
              state_d = S_NEXT;
            end
          end
        end
        S_NEXT: begin
          if ((count_q != '0) && (words_sent_q == count_q)) begin
            done    = 1'b1;
            state_d = S_IDLE;
          end else begin
            state_d = S_CHK;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    tx_byte = word_q[WORD_W-1-8*int'(idx_q) -: 8];
  end

  assign bus.FifoReadEn = fifo_rd_en;
  assign bus.TxStart    = tx_start;
  assign bus.TxData     = tx_byte;
  assign bus.Busy       = (state_q != S_IDLE);
  assign bus.Done       = done;
  assign bus.WordsSent  = words_sent_q;
endmodule

// File: tb/tb_fifo_byte_sequencer.sv
// Scoreboard bench: expected bytes and WordsSent-at-Done are queued with the stimulus;
// a monitor pops and compares on every TxStart / Done.
module tb_fifo_byte_sequencer;
  logic clk;
  logic rst_n;

  fifo_byte_sequencer_if #(.WORD_W(32), .CNT_W(16)) bus ();

  fifo_byte_sequencer #(.WORD_W(32), .FIFO_RD_LAT(1), .CNT_W(16)) dut (
    .Clock   (clk),
    .Reset_n (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int n_txs = 0;
  int n_rd = 0;
  int n_done = 0;
  int cyc = 0;
  int first_rd_cyc = -1;
  int first_txs_cyc = -1;
  bit no_rise = 0;

  logic [31:0] fifo_q[$];
  logic [7:0]  exp_bytes[$];
  logic [15:0] exp_ws[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_word(input logic [31:0] w, input bit expect_bytes);
    fifo_q.push_back(w);
    if (expect_bytes) begin
      for (int i = 3; i >= 0; i--) exp_bytes.push_back(w[8*i +: 8]);
    end
  endtask

  always @(posedge clk) cyc++;

  // FIFO model: pop observed strobe, data valid one cycle later
  initial begin
    logic rd;
    bus.FifoEmpty = 1'b1;
    bus.FifoData  = '0;
    forever begin
      @(negedge clk);
      rd = bus.FifoReadEn;
      @(posedge clk);
      #1;
      if (rd && fifo_q.size() > 0) bus.FifoData = fifo_q.pop_front();
      bus.FifoEmpty = (fifo_q.size() == 0);
    end
  end

  // UART model: busy for 10 cycles starting the cycle after TxStart
  initial begin
    logic s;
    int bcnt;
    bcnt = 0;
    bus.TxBusy = 1'b0;
    forever begin
      @(negedge clk);
      s = bus.TxStart;
      @(posedge clk);
      #1;
      if (s && !no_rise) begin
        bus.TxBusy = 1'b1;
        bcnt = 10;
      end else if (bcnt > 0) begin
        bcnt--;
        if (bcnt == 0) bus.TxBusy = 1'b0;
      end
    end
  end

  // Monitor
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (bus.FifoReadEn) begin
          n_rd++;
          if (first_rd_cyc < 0) first_rd_cyc = cyc;
        end
        if (bus.TxStart) begin
          n_txs++;
          if (first_txs_cyc < 0) first_txs_cyc = cyc;
          if (exp_bytes.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL unexpected_txstart: got TxData %0h expected no TxStart", bus.TxData);
          end else begin
            check("tx_byte", {24'h0, bus.TxData}, {24'h0, exp_bytes.pop_front()});
          end
        end
        if (bus.Done) begin
          n_done++;
          if (exp_ws.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL unexpected_done: got WordsSent %0d expected no Done", bus.WordsSent);
          end else begin
            check("words_sent_at_done", {16'h0, bus.WordsSent}, {16'h0, exp_ws.pop_front()});
          end
        end
      end
    end
  end

  task automatic clear_counts();
    n_txs = 0;
    n_rd = 0;
    n_done = 0;
  endtask

  task automatic start_dump(input logic [15:0] cnt, output int start_cyc);
    @(posedge clk);
    #1;
    bus.Start = 1'b1;
    bus.WordCount = cnt;
    start_cyc = cyc;
    @(posedge clk);
    #1;
    bus.Start = 1'b0;
  endtask

  task automatic wait_done(input int target, input string name);
    bit ok;
    ok = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      #1;
      if (n_done >= target && !bus.Busy) begin
        ok = 1;
        break;
      end
    end
    if (!ok) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s_timeout: got Done count %0d expected %0d", name, n_done, target);
    end
  endtask

  task automatic wait_txs(input int target, input string name);
    bit ok;
    ok = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      #1;
      if (n_txs >= target) begin
        ok = 1;
        break;
      end
    end
    if (!ok) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s_timeout: got TxStart count %0d expected %0d", name, n_txs, target);
    end
  endtask

  initial begin
    int sc;
    rst_n = 1'b0;
    bus.Start = 1'b0;
    bus.Abort = 1'b0;
    bus.WordCount = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", {31'h0, bus.Busy}, 32'h0);
    check("rst_done", {31'h0, bus.Done}, 32'h0);
    check("rst_txstart", {31'h0, bus.TxStart}, 32'h0);
    check("rst_fifo_rd_en", {31'h0, bus.FifoReadEn}, 32'h0);
    check("rst_words_sent", {16'h0, bus.WordsSent}, 32'h0);
    check("rst_txdata", {24'h0, bus.TxData}, 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // T1: one word, count mode, plus latency
    clear_counts();
    first_rd_cyc = -1;
    first_txs_cyc = -1;
    push_word(32'hA1B2C3D4, 1);
    exp_ws.push_back(16'd1);
    start_dump(16'd1, sc);
    wait_done(1, "t1");
    check("t1_rd_latency", first_rd_cyc - sc, 32'd2);
    check("t1_txstart_latency", first_txs_cyc - sc, 32'd4);
    check("t1_txstarts", n_txs, 32'd4);
    check("t1_reads", n_rd, 32'd1);
    check("t1_dones", n_done, 32'd1);
    check("t1_words_sent", {16'h0, bus.WordsSent}, 32'd1);

    // T2: drain three words
    repeat (15) @(posedge clk);
    clear_counts();
    push_word(32'h11223344, 1);
    push_word(32'h55667788, 1);
    push_word(32'h99AABBCC, 1);
    exp_ws.push_back(16'd3);
    start_dump(16'd0, sc);
    wait_done(1, "t2");
    check("t2_txstarts", n_txs, 32'd12);
    check("t2_reads", n_rd, 32'd3);
    check("t2_words_sent", {16'h0, bus.WordsSent}, 32'd3);

    // T3: count 2, second word arrives late
    repeat (15) @(posedge clk);
    clear_counts();
    push_word(32'hDEADBEEF, 1);
    exp_ws.push_back(16'd2);
    start_dump(16'd2, sc);
    wait_txs(4, "t3_first_word");
    repeat (50) @(posedge clk);
    #1;
    check("t3_stall_busy", {31'h0, bus.Busy}, 32'h1);
    check("t3_stall_reads", n_rd, 32'd1);
    check("t3_stall_dones", n_done, 32'd0);
    push_word(32'hCAFEF00D, 1);
    wait_done(1, "t3");
    check("t3_txstarts", n_txs, 32'd8);
    check("t3_reads", n_rd, 32'd2);
    check("t3_words_sent", {16'h0, bus.WordsSent}, 32'd2);

    // T4: abort during second byte, then a fresh dump
    repeat (15) @(posedge clk);
    clear_counts();
    fifo_q.push_back(32'h01020304);
    exp_bytes.push_back(8'h01);
    exp_bytes.push_back(8'h02);
    push_word(32'h05060708, 0);
    start_dump(16'd2, sc);
    wait_txs(2, "t4_second_byte");
    @(posedge clk);
    #1;
    bus.Abort = 1'b1;
    @(posedge clk);
    #1;
    bus.Abort = 1'b0;
    @(negedge clk);
    check("t4_abort_busy", {31'h0, bus.Busy}, 32'h0);
    repeat (40) @(posedge clk);
    #1;
    check("t4_abort_txstarts", n_txs, 32'd2);
    check("t4_abort_dones", n_done, 32'd0);
    check("t4_abort_words_sent", {16'h0, bus.WordsSent}, 32'd0);
    for (int i = 3; i >= 0; i--) exp_bytes.push_back(8'(32'h05060708 >> (8 * i)));
    exp_ws.push_back(16'd1);
    start_dump(16'd1, sc);
    wait_done(1, "t4_restart");
    check("t4_restart_txstarts", n_txs, 32'd6);

    // T5: Start while busy is ignored; Start+Abort starts nothing
    repeat (15) @(posedge clk);
    clear_counts();
    push_word(32'h0F1E2D3C, 1);
    exp_ws.push_back(16'd1);
    start_dump(16'd1, sc);
    repeat (3) @(posedge clk);
    start_dump(16'd5, sc);
    wait_done(1, "t5");
    check("t5_txstarts", n_txs, 32'd4);
    check("t5_words_sent", {16'h0, bus.WordsSent}, 32'd1);
    repeat (15) @(posedge clk);
    clear_counts();
    push_word(32'h77777777, 0);
    @(posedge clk);
    #1;
    bus.Start = 1'b1;
    bus.Abort = 1'b1;
    bus.WordCount = 16'd1;
    @(posedge clk);
    #1;
    bus.Start = 1'b0;
    bus.Abort = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("t5_start_abort_busy", {31'h0, bus.Busy}, 32'h0);
    check("t5_start_abort_reads", n_rd, 32'd0);
    fifo_q.delete();

    // T6: async reset mid-TXBUSY of the second word
    repeat (5) @(posedge clk);
    clear_counts();
    push_word(32'h13579BDF, 1);
    fifo_q.push_back(32'h2468ACE0);
    exp_bytes.push_back(8'h24);
    start_dump(16'd2, sc);
    wait_txs(5, "t6_second_word");
    repeat (4) @(posedge clk);
    #1;
    check("t6_pre_words_sent", {16'h0, bus.WordsSent}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_busy", {31'h0, bus.Busy}, 32'h0);
    check("t6_words_sent", {16'h0, bus.WordsSent}, 32'h0);
    check("t6_txdata", {24'h0, bus.TxData}, 32'h0);
    check("t6_txstart", {31'h0, bus.TxStart}, 32'h0);
    fifo_q.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    check("t6_idle_after", {31'h0, bus.Busy}, 32'h0);

    // T7: UART never raises TxBusy; must not deadlock
    clear_counts();
    no_rise = 1;
    push_word(32'h8899AABB, 1);
    exp_ws.push_back(16'd1);
    start_dump(16'd1, sc);
    wait_done(1, "t7");
    check("t7_txstarts", n_txs, 32'd4);
    no_rise = 0;

    repeat (5) @(posedge clk);
    check("leftover_bytes", exp_bytes.size(), 32'd0);
    check("leftover_done", exp_ws.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
